// File: rtl/snake_body_engine.sv
// Snake segment store: moves the head on a STEP grid, shifts the body behind it,
// detects wall/self collisions and streams segments head->tail over a valid/ready port.
module snake_body_engine #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int STEP     = 10,
  parameter int XMAX     = 150,
  parameter int YMAX     = 110,
  parameter int X0       = 79,
  parameter int Y0       = 59,
  parameter int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          CLOCK_50,
  input  logic          Resetn,
  input  logic          init,
  input  logic          step,
  input  logic [1:0]    dir,
  input  logic          grow,
  input  logic          scan_start,
  input  logic          seg_ready,
  output logic          seg_valid,
  output logic [XW-1:0] seg_x,
  output logic [YW-1:0] seg_y,
  output logic          seg_last,
  output logic          busy,
  output logic [LW-1:0] length,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic          dead,
  output logic          wall_hit,
  output logic          self_hit
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [XW:0]   XLIM = (XW+1)'(XMAX);
  localparam logic [YW:0]   YLIM = (YW+1)'(YMAX);
  localparam logic [XW-1:0] SX   = XW'(STEP);
  localparam logic [YW-1:0] SY   = YW'(STEP);

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT, SCAN} state_t;

  state_t state, state_nxt;

  logic [XW-1:0] seg_xs [MAX_LEN];
  logic [YW-1:0] seg_ys [MAX_LEN];
  logic [LW-1:0] len;
  logic [1:0]    cur_dir;
  logic          dead_r, wall_r, self_r;
  logic [XW-1:0] nxt_x;
  logic [YW-1:0] nxt_y;
  logic          grow_l;
  logic [IW-1:0] idx;

  logic          reload;
  logic [1:0]    mv_dir;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;
  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;
  logic          cand_wall;
  logic          chk_match, chk_done, scan_last;
  logic [LW-1:0] chk_last;

  logic step_take, start_move, wall_now, chk_next, self_now, commit, scan_xfer;

  assign reload = !Resetn || init;

  // Candidate head for a move; a reversal request keeps the current heading.
  always_comb begin
    mv_dir    = ((dir ^ cur_dir) == 2'b11) ? cur_dir : dir;
    sum_x     = {1'b0, seg_xs[0]} + {1'b0, SX};
    sum_y     = {1'b0, seg_ys[0]} + {1'b0, SY};
    cand_x    = seg_xs[0];
    cand_y    = seg_ys[0];
    cand_wall = 1'b0;
    case (mv_dir)
      2'b00: begin
        cand_x    = sum_x[XW-1:0];
        cand_wall = sum_x > XLIM;
      end
      2'b01: begin
        cand_y    = sum_y[YW-1:0];
        cand_wall = sum_y > YLIM;
      end
      2'b10: begin
        cand_y    = seg_ys[0] - SY;
        cand_wall = seg_ys[0] < SY;
      end
      default: begin
        cand_x    = seg_xs[0] - SX;
        cand_wall = seg_xs[0] < SX;
      end
    endcase
  end

  // The tail only joins the body test when it will not vacate its cell this move.
  always_comb begin
    chk_match = (seg_xs[idx] == nxt_x) && (seg_ys[idx] == nxt_y);
    chk_last  = grow_l ? (len - LW'(1)) : (len - LW'(2));
    chk_done  = LW'(idx) == chk_last;
    scan_last = LW'(idx) == (len - LW'(1));
  end

  always_ff @(posedge CLOCK_50) begin
    state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    step_take  = 1'b0;
    start_move = 1'b0;
    wall_now   = 1'b0;
    chk_next   = 1'b0;
    self_now   = 1'b0;
    commit     = 1'b0;
    scan_xfer  = 1'b0;
    case (state)
      IDLE: begin
        if (step) begin
          if (!dead_r) begin
            step_take = 1'b1;
            if (cand_wall) begin
              wall_now = 1'b1;
            end else begin
              start_move = 1'b1;
              state_nxt  = (grow || len > LW'(2)) ? CHECK : COMMIT;
            end
          end
        end else if (scan_start) begin
          state_nxt = SCAN;
        end
      end
      CHECK: begin
        if (chk_match) begin
          self_now  = 1'b1;
          state_nxt = IDLE;
        end else if (chk_done) begin
          state_nxt = COMMIT;
        end else begin
          chk_next = 1'b1;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      SCAN: begin
        if (seg_ready) begin
          scan_xfer = 1'b1;
          if (scan_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (reload) state_nxt = IDLE;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reload) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          seg_xs[i] <= XW'(X0 - i * STEP);
          seg_ys[i] <= YW'(Y0);
        end else begin
          seg_xs[i] <= '0;
          seg_ys[i] <= '0;
        end
      end
      len     <= LW'(INIT_LEN);
      cur_dir <= 2'b00;
      dead_r  <= 1'b0;
      wall_r  <= 1'b0;
      self_r  <= 1'b0;
      nxt_x   <= '0;
      nxt_y   <= '0;
      grow_l  <= 1'b0;
      idx     <= '0;
    end else begin
      if (step_take) cur_dir <= mv_dir;
      if (wall_now) begin
        dead_r <= 1'b1;
        wall_r <= 1'b1;
      end
      if (start_move) begin
        nxt_x  <= cand_x;
        nxt_y  <= cand_y;
        grow_l <= grow;
        idx    <= IW'(1);
      end
      if (chk_next) idx <= idx + IW'(1);
      if (self_now) begin
        dead_r <= 1'b1;
        self_r <= 1'b1;
        idx    <= '0;
      end
      if (commit) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_xs[i] <= seg_xs[i-1];
          seg_ys[i] <= seg_ys[i-1];
        end
        seg_xs[0] <= nxt_x;
        seg_ys[0] <= nxt_y;
        if (grow_l && len < LW'(MAX_LEN)) len <= len + LW'(1);
        idx <= '0;
      end
      if (scan_xfer) idx <= scan_last ? '0 : idx + IW'(1);
    end
  end

  assign seg_valid = (state == SCAN);
  assign seg_x     = seg_xs[idx];
  assign seg_y     = seg_ys[idx];
  assign seg_last  = seg_valid && scan_last;
  assign busy      = (state != IDLE);
  assign length    = len;
  assign head_x    = seg_xs[0];
  assign head_y    = seg_ys[0];
  assign dead      = dead_r;
  assign wall_hit  = wall_r;
  assign self_hit  = self_r;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: vector table, hand-written corner sequences and
// randomized moves/scans against a queue-based snake model.
module tb_snake_body_engine;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn, init, step, grow, scan_start, seg_ready;
  logic [1:0] dir;
  logic       seg_valid, seg_last, busy, dead, wall_hit, self_hit;
  logic [7:0] seg_x, head_x;
  logic [6:0] seg_y, head_y;
  logic [4:0] length;

  int checks = 0;
  int failures = 0;

  snake_body_engine dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .init(init), .step(step), .dir(dir),
    .grow(grow), .scan_start(scan_start), .seg_ready(seg_ready),
    .seg_valid(seg_valid), .seg_x(seg_x), .seg_y(seg_y), .seg_last(seg_last),
    .busy(busy), .length(length), .head_x(head_x), .head_y(head_y),
    .dead(dead), .wall_hit(wall_hit), .self_hit(self_hit)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Reference snake: queue of cells, head at index 0.
  int  mx[$], my[$];
  int  m_dir;
  bit  m_dead, m_wall, m_self;
  int  bx[$], by[$], bl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    mx.delete();
    my.delete();
    for (int i = 0; i < 4; i++) begin
      mx.push_back(79 - 10 * i);
      my.push_back(59);
    end
    m_dir  = 0;
    m_dead = 0;
    m_wall = 0;
    m_self = 0;
  endfunction

  // Returns the expected number of busy cycles for this move.
  function automatic int model_step(input int d, input bit g);
    int e, nx, ny, n, ncmp;
    if (m_dead) return 0;
    e = d;
    if ((d == 0 && m_dir == 3) || (d == 3 && m_dir == 0) ||
        (d == 1 && m_dir == 2) || (d == 2 && m_dir == 1)) e = m_dir;
    m_dir = e;
    nx = mx[0];
    ny = my[0];
    case (e)
      0: nx = nx + 10;
      1: ny = ny + 10;
      2: ny = ny - 10;
      default: nx = nx - 10;
    endcase
    if (nx > 150 || nx < 0 || ny > 110 || ny < 0) begin
      m_dead = 1;
      m_wall = 1;
      return 0;
    end
    n = mx.size();
    ncmp = g ? n - 1 : n - 2;
    for (int j = 1; j <= ncmp; j++) begin
      if (mx[j] == nx && my[j] == ny) begin
        m_dead = 1;
        m_self = 1;
        return j;
      end
    end
    mx.push_front(nx);
    my.push_front(ny);
    if (!(g && n < 16)) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    return ncmp + 1;
  endfunction

  task automatic do_init();
    @(negedge CLOCK_50);
    init = 1'b1;
    @(negedge CLOCK_50);
    init = 1'b0;
  endtask

  task automatic do_step(input logic [1:0] d, input bit g, output int bc);
    @(negedge CLOCK_50);
    dir  = d;
    grow = g;
    step = 1'b1;
    @(negedge CLOCK_50);
    step = 1'b0;
    bc = 0;
    while (busy && bc < 200) begin
      bc++;
      @(negedge CLOCK_50);
    end
    if (bc >= 200) chk("step_timeout", bc, 0);
  endtask

  // mode 1: always ready; mode 0: random backpressure.
  task automatic scan_run(input int mode);
    int  cyc, px, py;
    bit  prev_stall, done, r;
    bx.delete();
    by.delete();
    bl.delete();
    @(negedge CLOCK_50);
    scan_start = 1'b1;
    @(negedge CLOCK_50);
    scan_start = 1'b0;
    done = 0;
    cyc = 0;
    prev_stall = 0;
    px = 0;
    py = 0;
    while (!done && cyc < 400) begin
      if (prev_stall) begin
        chk("scan_hold_valid", seg_valid, 1);
        chk("scan_hold_x", seg_x, px);
        chk("scan_hold_y", seg_y, py);
      end
      r = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      seg_ready = r;
      if (seg_valid && r) begin
        bx.push_back(seg_x);
        by.push_back(seg_y);
        bl.push_back(seg_last);
        if (seg_last) done = 1;
      end
      prev_stall = seg_valid && !r;
      px = seg_x;
      py = seg_y;
      cyc++;
      @(negedge CLOCK_50);
    end
    seg_ready = 1'b0;
    if (!done) chk("scan_timeout", cyc, 0);
    chk("scan_end_valid", seg_valid, 0);
    chk("scan_end_busy", busy, 0);
  endtask

  task automatic scan_vs_model(input string tag);
    chk({tag, "_beats"}, bx.size(), mx.size());
    for (int k = 0; k < bx.size() && k < mx.size(); k++) begin
      chk($sformatf("%s_x%0d", tag, k), bx[k], mx[k]);
      chk($sformatf("%s_y%0d", tag, k), by[k], my[k]);
      chk($sformatf("%s_last%0d", tag, k), bl[k], (k == mx.size() - 1) ? 1 : 0);
    end
  endtask

  task automatic chk_state(input string tag, input int bc, input int eb);
    chk({tag, "_hx"}, head_x, mx[0]);
    chk({tag, "_hy"}, head_y, my[0]);
    chk({tag, "_len"}, length, mx.size());
    chk({tag, "_dead"}, dead, m_dead);
    chk({tag, "_wall"}, wall_hit, m_wall);
    chk({tag, "_self"}, self_hit, m_self);
    chk({tag, "_busy"}, bc, eb);
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] d;
    bit         g;
    int         hx, hy, len;
    bit         dd, wl, sf;
    int         bsy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int bc, eb;
    int ex [4];
    int rd, rg;

    vecs.push_back('{1, 2'b01, 0, 79, 69, 4, 0, 0, 0, 3});
    vecs.push_back('{1, 2'b11, 0, 89, 59, 4, 0, 0, 0, 3});
    vecs.push_back('{1, 2'b00, 0, 89, 59, 4, 0, 0, 0, 3});
    vecs.push_back('{0, 2'b00, 0, 99, 59, 4, 0, 0, 0, 3});
    vecs.push_back('{0, 2'b00, 0, 109, 59, 4, 0, 0, 0, 3});
    vecs.push_back('{0, 2'b00, 0, 119, 59, 4, 0, 0, 0, 3});
    vecs.push_back('{0, 2'b00, 0, 129, 59, 4, 0, 0, 0, 3});
    vecs.push_back('{0, 2'b00, 0, 139, 59, 4, 0, 0, 0, 3});
    vecs.push_back('{0, 2'b00, 0, 149, 59, 4, 0, 0, 0, 3});
    vecs.push_back('{0, 2'b00, 0, 149, 59, 4, 1, 1, 0, 0});
    vecs.push_back('{0, 2'b01, 0, 149, 59, 4, 1, 1, 0, 0});
    vecs.push_back('{1, 2'b00, 1, 89, 59, 5, 0, 0, 0, 4});
    vecs.push_back('{0, 2'b01, 0, 89, 69, 5, 0, 0, 0, 4});
    vecs.push_back('{0, 2'b11, 0, 79, 69, 5, 0, 0, 0, 4});
    vecs.push_back('{0, 2'b10, 0, 79, 69, 5, 1, 0, 1, 3});
    vecs.push_back('{1, 2'b00, 0, 89, 59, 4, 0, 0, 0, 3});
    vecs.push_back('{0, 2'b01, 0, 89, 69, 4, 0, 0, 0, 3});
    vecs.push_back('{0, 2'b11, 0, 79, 69, 4, 0, 0, 0, 3});
    vecs.push_back('{0, 2'b10, 0, 79, 59, 4, 0, 0, 0, 3});

    Resetn = 1'b0; init = 1'b0; step = 1'b0; dir = 2'b00; grow = 1'b0;
    scan_start = 1'b0; seg_ready = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    Resetn = 1'b1;
    model_reset();

    chk("rst_valid", seg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len", length, 4);
    chk("rst_hx", head_x, 79);
    chk("rst_hy", head_y, 59);
    chk("rst_dead", dead, 0);

    // Initial snake streamed with the consumer always ready.
    scan_run(1);
    ex = '{79, 69, 59, 49};
    chk("scan0_beats", bx.size(), 4);
    for (int k = 0; k < 4 && k < bx.size(); k++) begin
      chk($sformatf("scan0_x%0d", k), bx[k], ex[k]);
      chk($sformatf("scan0_y%0d", k), by[k], 59);
      chk($sformatf("scan0_last%0d", k), bl[k], (k == 3) ? 1 : 0);
    end

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_init();
        model_reset();
      end
      eb = model_step(vecs[i].d, vecs[i].g);
      do_step(vecs[i].d, vecs[i].g, bc);
      chk($sformatf("v%0d_hx", i), head_x, vecs[i].hx);
      chk($sformatf("v%0d_hy", i), head_y, vecs[i].hy);
      chk($sformatf("v%0d_len", i), length, vecs[i].len);
      chk($sformatf("v%0d_dead", i), dead, vecs[i].dd);
      chk($sformatf("v%0d_wall", i), wall_hit, vecs[i].wl);
      chk($sformatf("v%0d_self", i), self_hit, vecs[i].sf);
      chk($sformatf("v%0d_busy", i), bc, vecs[i].bsy);
    end

    // Body after a single down move: tail must sit at (59,59).
    do_init();
    model_reset();
    eb = model_step(1, 0);
    do_step(2'b01, 1'b0, bc);
    scan_run(1);
    scan_vs_model("down");
    if (bx.size() == 4) begin
      chk("down_tail_x", bx[3], 59);
      chk("down_tail_y", by[3], 59);
    end

    // Grow on every move until saturation, then once more.
    do_init();
    model_reset();
    for (int s = 0; s < 13; s++) begin
      rd = (s < 7) ? 0 : ((s < 12) ? 1 : 3);
      eb = model_step(rd, 1);
      do_step(rd[1:0], 1'b1, bc);
      chk_state($sformatf("grow%0d", s), bc, eb);
    end
    chk("grow_sat_len", length, 16);
    scan_run(0);
    scan_vs_model("growscan");

    // step and scan_start together: the move wins, no scan follows.
    do_init();
    model_reset();
    eb = model_step(0, 0);
    @(negedge CLOCK_50);
    dir = 2'b00; grow = 1'b0; step = 1'b1; scan_start = 1'b1;
    @(negedge CLOCK_50);
    step = 1'b0; scan_start = 1'b0;
    bc = 0;
    while (busy && bc < 200) begin
      chk("both_no_scan", seg_valid, 0);
      bc++;
      @(negedge CLOCK_50);
    end
    chk_state("both", bc, eb);
    chk("both_valid", seg_valid, 0);

    // init aborts a move in progress.
    do_init();
    model_reset();
    @(negedge CLOCK_50);
    dir = 2'b01; step = 1'b1;
    @(negedge CLOCK_50);
    step = 1'b0;
    chk("abort_busy_mid", busy, 1);
    init = 1'b1;
    @(negedge CLOCK_50);
    init = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hx", head_x, 79);
    chk("abort_hy", head_y, 59);

    // init during a stalled scan after growth.
    do_init();
    model_reset();
    eb = model_step(0, 1);
    do_step(2'b00, 1'b1, bc);
    chk("pre_len", length, 5);
    @(negedge CLOCK_50);
    scan_start = 1'b1; seg_ready = 1'b0;
    @(negedge CLOCK_50);
    scan_start = 1'b0;
    chk("stall_valid", seg_valid, 1);
    chk("stall_x", seg_x, 89);
    @(negedge CLOCK_50);
    chk("stall_hold_x", seg_x, 89);
    chk("stall_busy", busy, 1);
    init = 1'b1;
    @(negedge CLOCK_50);
    init = 1'b0;
    model_reset();
    chk("init_scan_valid", seg_valid, 0);
    chk("init_scan_len", length, 4);
    chk("init_scan_busy", busy, 0);

    // Randomized moves and scans against the model.
    for (int n = 0; n < 400; n++) begin
      rd = $urandom_range(0, 3);
      rg = ($urandom_range(0, 3) == 0) ? 1 : 0;
      eb = model_step(rd, rg[0]);
      do_step(rd[1:0], rg[0], bc);
      chk_state($sformatf("rnd%0d", n), bc, eb);
      if (n % 25 == 7) begin
        scan_run(0);
        scan_vs_model($sformatf("rscan%0d", n));
      end
      if (m_dead && $urandom_range(0, 1) == 1) begin
        do_init();
        model_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
